// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage.
//   NOP_INST     canonical bubble instruction (addi x0,x0,0)
//   EBREAK_INST  / ECALL_INST  encodings that stop fetching
//   PC_INC       sequential PC step in bytes
//   fetch_state_e  fetch state machine encoding
package fetch_stage_pkg;

   localparam logic [31:0] NOP_INST    = 32'h0000_0013;
   localparam logic [31:0] EBREAK_INST = 32'h0010_0073;
   localparam logic [31:0] ECALL_INST  = 32'h0000_0073;
   localparam logic [31:0] PC_INC      = 32'd4;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } fetch_state_e;

   function automatic logic is_halt_inst(input logic [31:0] inst);
      return (inst == EBREAK_INST) || (inst == ECALL_INST);
   endfunction

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   load                  capture next_pc/next_pc4/next_inst as a valid entry
//   flush                 replace contents with an invalid NOP bubble
//   hold                  keep current contents
//   next_pc, next_pc4, next_inst   fetched entry to capture
//   valid, pc, pc4, inst  register contents
// Priority: rst > flush > hold > load; with no control asserted the
// contents are kept.
module ifid_reg
   import fetch_stage_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        flush,
   input  logic        hold,
   input  logic [31:0] next_pc,
   input  logic [31:0] next_pc4,
   input  logic [31:0] next_inst,
   output logic        valid,
   output logic [31:0] pc,
   output logic [31:0] pc4,
   output logic [31:0] inst
);

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         valid <= 1'b0;
         pc    <= '0;
         pc4   <= '0;
         inst  <= NOP_INST;
      end else if (!hold && load) begin
         valid <= 1'b1;
         pc    <= next_pc;
         pc4   <= next_pc4;
         inst  <= next_inst;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, RUN/HALT sequencing, IF/ID
// register and fetched-instruction counter.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   stall                            hold PC, IF/ID and counter
//   redirect_valid, redirect_target  taken branch/jump (wins over stall)
//   imem_addr, imem_data             word address out, instruction in (combinational)
//   pc                               current fetch PC
//   ifid_valid/pc/pc4/inst           IF/ID register contents
//   halted                           high in HALT
//   fetch_count                      valid instructions latched into IF/ID
//
// state | meaning
// RUN   | fetching sequentially, honouring stall and redirect
// HALT  | ebreak/ecall fetched; PC frozen, bubbles issued until a redirect
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          IMEM_AW  = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               stall,
   input  logic               redirect_valid,
   input  logic [31:0]        redirect_target,
   output logic [IMEM_AW-1:0] imem_addr,
   input  logic [31:0]        imem_data,
   output logic [31:0]        pc,
   output logic               ifid_valid,
   output logic [31:0]        ifid_pc,
   output logic [31:0]        ifid_pc4,
   output logic [31:0]        ifid_inst,
   output logic               halted,
   output logic [31:0]        fetch_count
);

   fetch_state_e state, state_next;
   logic [31:0]  pc_next;
   logic [31:0]  pc_seq;
   logic [31:0]  target_aligned;
   logic         ifid_load, ifid_flush, ifid_hold, count_inc;

   assign pc_seq         = pc + PC_INC;
   assign target_aligned = redirect_target & ~32'h3;
   assign imem_addr      = pc[IMEM_AW+1:2];
   assign halted         = (state == HALT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= RUN;
         pc          <= RESET_PC;
         fetch_count <= '0;
      end else begin
         state <= state_next;
         pc    <= pc_next;
         if (count_inc) fetch_count <= fetch_count + 32'd1;
      end
   end

   always_comb begin
      state_next = state;
      pc_next    = pc;
      ifid_load  = 1'b0;
      ifid_flush = 1'b0;
      ifid_hold  = 1'b0;
      count_inc  = 1'b0;
      unique case (state)
         RUN: begin
            if (redirect_valid) begin
               pc_next    = target_aligned;
               ifid_flush = 1'b1;
            end else if (stall) begin
               ifid_hold = 1'b1;
            end else begin
               pc_next   = pc_seq;
               ifid_load = 1'b1;
               count_inc = 1'b1;
               // The halting word is still delivered downstream as a valid entry.
               if (is_halt_inst(imem_data)) state_next = HALT;
            end
         end
         HALT: begin
            ifid_flush = 1'b1;
            // The halting instruction was on a wrong path; resume at the target.
            if (redirect_valid) begin
               pc_next    = target_aligned;
               state_next = RUN;
            end
         end
         default: state_next = RUN;
      endcase
   end

   ifid_reg u_ifid_reg (
      .clk       (clk),
      .rst       (rst),
      .load      (ifid_load),
      .flush     (ifid_flush),
      .hold      (ifid_hold),
      .next_pc   (pc),
      .next_pc4  (pc_seq),
      .next_inst (imem_data),
      .valid     (ifid_valid),
      .pc        (ifid_pc),
      .pc4       (ifid_pc4),
      .inst      (ifid_inst)
   );

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

   localparam int AW = 8;
   localparam logic [31:0] NOP    = 32'h0000_0013;
   localparam logic [31:0] EBREAK = 32'h0010_0073;
   localparam logic [31:0] ECALL  = 32'h0000_0073;

   logic          clk = 1'b0;
   logic          rst, stall, redirect_valid;
   logic [31:0]   redirect_target;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_data;
   logic [31:0]   pc, ifid_pc, ifid_pc4, ifid_inst, fetch_count;
   logic          ifid_valid, halted;

   logic [31:0] mem [2**AW];
   assign imem_data = mem[imem_addr];

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   fetch_stage #(.RESET_PC(32'h0), .IMEM_AW(AW)) dut (
      .clk             (clk),
      .rst             (rst),
      .stall           (stall),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .imem_addr       (imem_addr),
      .imem_data       (imem_data),
      .pc              (pc),
      .ifid_valid      (ifid_valid),
      .ifid_pc         (ifid_pc),
      .ifid_pc4        (ifid_pc4),
      .ifid_inst       (ifid_inst),
      .halted          (halted),
      .fetch_count     (fetch_count)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %08h, want %08h", name, act, exp);
   endtask

   // Drive one cycle's inputs, clock it, sample 1ns after the edge.
   task automatic cycle(input logic r, input logic s, input logic rv, input logic [31:0] t);
      rst = r; stall = s; redirect_valid = rv; redirect_target = t;
      @(posedge clk);
      #1;
   endtask

   task automatic fill_image();
      for (int i = 0; i < 2**AW; i++) mem[i] = 32'h0000_0093 | (32'(i) << 20);
      mem[2] = 32'h0050_0113;
   endtask

   typedef struct {
      logic        r, s, rv;
      logic [31:0] tgt;
      logic [31:0] e_pc;
      logic        e_valid;
      logic [31:0] e_ipc, e_ipc4, e_inst, e_cnt;
      logic        e_halt;
   } vec_t;

   vec_t vt [11];

   // Reference model state.
   logic [31:0] m_pc, m_ipc, m_ipc4, m_inst, m_cnt;
   logic        m_valid, m_halt;

   task automatic model_step(input logic r, input logic s, input logic rv, input logic [31:0] t);
      logic [31:0] word;
      if (r) begin
         m_pc = 0; m_halt = 0; m_valid = 0; m_ipc = 0; m_ipc4 = 0; m_inst = NOP; m_cnt = 0;
      end else if (m_halt) begin
         m_valid = 0; m_inst = NOP; m_ipc = 0; m_ipc4 = 0;
         if (rv) begin m_pc = t & ~32'h3; m_halt = 0; end
      end else if (rv) begin
         m_pc = t & ~32'h3; m_valid = 0; m_inst = NOP; m_ipc = 0; m_ipc4 = 0;
      end else if (!s) begin
         word = mem[m_pc[AW+1:2]];
         m_valid = 1; m_ipc = m_pc; m_ipc4 = m_pc + 4; m_inst = word;
         m_cnt = m_cnt + 1;
         m_pc = m_pc + 4;
         if (word == EBREAK || word == ECALL) m_halt = 1;
      end
   endtask

   initial begin
      rst = 1; stall = 0; redirect_valid = 0; redirect_target = 0;
      fill_image();

      //        r  s  rv tgt      pc     v  ipc    ipc4   inst          cnt h
      vt[0]  = '{1, 0, 0, 32'h0,  32'h0,  0, 32'h0, 32'h0, NOP,          0, 0};
      vt[1]  = '{1, 0, 0, 32'h0,  32'h0,  0, 32'h0, 32'h0, NOP,          0, 0};
      vt[2]  = '{0, 0, 0, 32'h0,  32'h4,  1, 32'h0, 32'h4, 32'h00000093, 1, 0};
      vt[3]  = '{0, 0, 0, 32'h0,  32'h8,  1, 32'h4, 32'h8, 32'h00100093, 2, 0};
      vt[4]  = '{0, 0, 0, 32'h0,  32'hC,  1, 32'h8, 32'hC, 32'h00500113, 3, 0};
      vt[5]  = '{0, 1, 0, 32'h0,  32'hC,  1, 32'h8, 32'hC, 32'h00500113, 3, 0};
      vt[6]  = '{0, 1, 0, 32'h0,  32'hC,  1, 32'h8, 32'hC, 32'h00500113, 3, 0};
      vt[7]  = '{0, 0, 0, 32'h0,  32'h10, 1, 32'hC, 32'h10,32'h00300093, 4, 0};
      vt[8]  = '{0, 1, 1, 32'h96, 32'h94, 0, 32'h0, 32'h0, NOP,          4, 0};
      vt[9]  = '{0, 0, 0, 32'h0,  32'h98, 1, 32'h94,32'h98,32'h02500093, 5, 0};
      vt[10] = '{1, 1, 1, 32'h40, 32'h0,  0, 32'h0, 32'h0, NOP,          0, 0};

      foreach (vt[i]) begin
         cycle(vt[i].r, vt[i].s, vt[i].rv, vt[i].tgt);
         check($sformatf("vec%0d pc", i),        pc,          vt[i].e_pc);
         check($sformatf("vec%0d imem_addr", i), 32'(imem_addr), 32'(vt[i].e_pc[AW+1:2]));
         check($sformatf("vec%0d valid", i),     32'(ifid_valid), 32'(vt[i].e_valid));
         check($sformatf("vec%0d ifid_pc", i),   ifid_pc,     vt[i].e_ipc);
         check($sformatf("vec%0d ifid_pc4", i),  ifid_pc4,    vt[i].e_ipc4);
         check($sformatf("vec%0d inst", i),      ifid_inst,   vt[i].e_inst);
         check($sformatf("vec%0d count", i),     fetch_count, vt[i].e_cnt);
         check($sformatf("vec%0d halted", i),    32'(halted), 32'(vt[i].e_halt));
      end

      // ebreak at 0xF8, halt, stall ignored, redirect out of HALT.
      mem[8'h3E] = EBREAK;
      cycle(1, 0, 0, 0);
      cycle(0, 0, 1, 32'hF8);
      check("brk pc_before", pc, 32'hF8);
      cycle(0, 0, 0, 0);
      check("brk inst", ifid_inst, EBREAK);
      check("brk valid", 32'(ifid_valid), 1);
      check("brk ifid_pc", ifid_pc, 32'hF8);
      check("brk halted", 32'(halted), 1);
      check("brk pc", pc, 32'hFC);
      check("brk count", fetch_count, 1);
      cycle(0, 1, 0, 0);
      check("halt hold pc", pc, 32'hFC);
      check("halt bubble valid", 32'(ifid_valid), 0);
      check("halt bubble inst", ifid_inst, NOP);
      check("halt count", fetch_count, 1);
      check("halt still", 32'(halted), 1);
      cycle(0, 1, 1, 32'h41);
      check("resume halted", 32'(halted), 0);
      check("resume pc", pc, 32'h40);
      cycle(0, 0, 0, 0);
      check("resume fetch pc", pc, 32'h44);
      check("resume fetch inst", ifid_inst, 32'h01000093);
      check("resume count", fetch_count, 2);

      // imem_addr wrap and 32-bit PC wrap.
      cycle(0, 0, 1, 32'h3FC);
      check("wrap imem_addr pre", 32'(imem_addr), 32'hFF);
      cycle(0, 0, 0, 0);
      check("wrap pc", pc, 32'h400);
      check("wrap imem_addr", 32'(imem_addr), 0);
      check("wrap inst", ifid_inst, 32'h0FF00093);
      cycle(0, 0, 1, 32'hFFFF_FFFC);
      cycle(0, 0, 0, 0);
      check("pc32 wrap", pc, 32'h0);
      check("pc32 wrap pc4", ifid_pc4, 32'h0);

      // ecall halt, then reset inside HALT.
      mem[8'h20] = ECALL;
      cycle(0, 0, 1, 32'h80);
      cycle(0, 0, 0, 0);
      check("ecall halted", 32'(halted), 1);
      check("ecall pc", pc, 32'h84);
      cycle(1, 1, 1, 32'h40);
      check("rst halt pc", pc, 32'h0);
      check("rst halt halted", 32'(halted), 0);
      check("rst halt valid", 32'(ifid_valid), 0);
      check("rst halt inst", ifid_inst, NOP);
      check("rst halt ifid_pc", ifid_pc, 0);
      check("rst halt ifid_pc4", ifid_pc4, 0);
      check("rst halt count", fetch_count, 0);

      // Randomized run against the reference model.
      for (int i = 0; i < 2**AW; i++) begin
         mem[i] = $urandom;
         if ($urandom_range(0, 15) == 0) mem[i] = $urandom_range(0, 1) ? EBREAK : ECALL;
      end
      cycle(1, 0, 0, 0);
      model_step(1, 0, 0, 0);
      for (int n = 0; n < 800; n++) begin
         logic r, s, rv;
         logic [31:0] t;
         r  = ($urandom_range(0, 99) < 2);
         s  = ($urandom_range(0, 99) < 25);
         rv = ($urandom_range(0, 99) < 12);
         t  = $urandom;
         if ($urandom_range(0, 1) == 1) t = t & 32'h0000_03FF;
         model_step(r, s, rv, t);
         cycle(r, s, rv, t);
         check("rnd pc", pc, m_pc);
         check("rnd imem_addr", 32'(imem_addr), 32'(m_pc[AW+1:2]));
         check("rnd valid", 32'(ifid_valid), 32'(m_valid));
         check("rnd inst", ifid_inst, m_inst);
         check("rnd count", fetch_count, m_cnt);
         check("rnd halted", 32'(halted), 32'(m_halt));
         if (m_valid) begin
            check("rnd ifid_pc", ifid_pc, m_ipc);
            check("rnd ifid_pc4", ifid_pc4, m_ipc4);
         end
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the PC value loaded on reset.
REQ-002 The block SHALL have parameter IMEM_AW, default 8, giving the instruction-memory word-address width.
REQ-003 The block SHALL have port clk  in  1  single system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 The block SHALL have port stall  in  1  hold the PC and the IF/ID register (load-use hazard).
REQ-006 The block SHALL have port redirect_valid  in  1  taken branch or jump resolved downstream.
REQ-007 The block SHALL have port redirect_target  in  32  new PC byte address.
REQ-008 The block SHALL have port imem_addr  out  IMEM_AW  word address to the instruction memory, equal to pc[IMEM_AW+1:2].
REQ-009 The block SHALL have port imem_data  in  32  instruction word returned combinationally for imem_addr.
REQ-010 The block SHALL have port pc  out  32  current fetch PC.
REQ-011 The block SHALL have port ifid_valid, ifid_pc, ifid_pc4 and ifid_inst  out  1/32/32/32  IF/ID pipeline register contents.
REQ-012 The block SHALL have port halted  out  1  high while the state machine is in HALT.
REQ-013 The block SHALL have port fetch_count  out  32  count of valid instructions latched into IF/ID.

Function
REQ-014 The block SHALL implement the two states RUN and HALT.
REQ-015 In RUN with no stall and no redirect, the block SHALL apply pc<=pc+4 and latch into IF/ID: valid=1, pc, pc+4 and imem_data; fetch_count SHALL increment.
REQ-016 In RUN, a redirect SHALL load pc<=redirect_target with bits [1:0] forced to 0, and SHALL load IF/ID with valid=0, inst=32'h00000013 (NOP) and pc/pc4=0.
REQ-017 Redirect SHALL take priority over stall.
REQ-018 Stall without redirect SHALL hold pc, the IF/ID register and fetch_count unchanged.
REQ-019 When the fetched word is ebreak (32'h00100073) or ecall (32'h00000073) with no stall and no redirect, the block SHALL latch the word normally and then transition to HALT.
REQ-020 In HALT, the block SHALL hold pc; each cycle it SHALL load IF/ID with valid=0 and inst=NOP; halted SHALL be 1.
REQ-021 In HALT, redirect_valid SHALL return the block to RUN with pc<=target, since the halting instruction was on a wrong path; stall SHALL be ignored.
REQ-022 The PC SHALL wrap modulo 2^32, and imem_addr SHALL wrap modulo 2^IMEM_AW words (PC 0x3FC -> 0x400 gives imem_addr 0x00 at default width).
REQ-023 fetch_count SHALL wrap from 0xFFFFFFFF to 0.
REQ-024 imem_addr SHALL be driven combinationally from pc, giving zero-cycle fetch latency; the instruction appears on ifid_inst one cycle after its PC is presented.

Reset
REQ-025 Reset SHALL override all other inputs.
REQ-026 The next edge after rst=1 SHALL give: pc=RESET_PC, state=RUN, ifid_valid=0, ifid_inst=NOP, ifid_pc=0, ifid_pc4=0, fetch_count=0, halted=0.
REQ-027 Reset asserted mid-stall, mid-redirect or in HALT SHALL produce the same result as REQ-026.

Structure
REQ-028 The shared package SHALL hold the NOP encoding 32'h00000013, the ebreak/ecall encodings, the PC increment 4 and the state enum {RUN, HALT}.
REQ-029 The IF/ID register SHALL be one sub-module, ifid_reg, with load, flush and hold controls; the PC, the state machine and the counter SHALL stay in fetch_stage.

Verification
REQ-030 Scenario: rst high for 2 cycles -> pc=0, imem_addr=0, ifid_valid=0, ifid_inst=0x00000013, fetch_count=0.
REQ-031 Scenario: run 3 cycles from reset with memory image word2=0x00500113 -> ifid_pc=0x8, ifid_pc4=0xC, ifid_inst=0x00500113, fetch_count=3.
REQ-032 Scenario: redirect_valid=1, target=0x96 while pc=0x84 -> next pc=0x94, ifid_valid=0, ifid_inst=NOP, fetch_count unchanged.
REQ-033 Scenario: stall=1 for 2 cycles at pc=0x20 -> pc and IF/ID are unchanged in both cycles; releasing the stall gives pc=0x24.
REQ-034 Scenario: ebreak at 0xF8 -> ifid_inst=0x00100073 with valid=1, then halted=1 and pc holds 0xFC; a following redirect to 0x40 gives halted=0 and pc=0x40.
REQ-035 Scenario: pc=0x3FC at IMEM_AW=8 -> next pc=0x400 with imem_addr=0x00; rst during HALT gives the REQ-026 values.
